round_norm: RTL
===============

ROUND_NORM -- requirements
Module: round_norm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have: in_valid in 1 upstream has data; in_ready out 1 block can accept.
REQ-004 SHALL have: in_sign in 1; in_exp in 11 biased exponent; in_rm in 2 rounding mode (00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf).
REQ-005 SHALL have: in_frac in 55 adder sum [54]=carry, [53]=hidden, [52:1]=fraction, [0]=guard; in_sticky in 1 OR of all bits shifted out during alignment.
REQ-006 SHALL have: out_valid out 1; out_ready in 1; out_sign out 1; out_exp out 11; out_frac out 52; out_inexact out 1; out_overflow out 1.

Function
REQ-007 SHALL be a 2-stage pipeline: S1 normalize, S2 round; transfer when valid&ready; out_valid 2 cycles after input accept; throughput 1/cycle when out_ready=1.
REQ-008 SHALL advance each stage when it is empty or the next stage advances; in_ready = S1 empty or S1 advancing (combinational from out_ready allowed).
REQ-009 SHALL hold all out_* stable while out_valid=1 and out_ready=0; no data loss, duplication or reordering.
REQ-010 S1: if in_frac[54]=1, shift right 1, exp+1, new guard = in_frac[1], sticky |= in_frac[0].
REQ-011 S1: else if in_frac[53]=0 and in_exp>0, shift left by min(leading zeros of in_frac[53:0], in_exp-1), exp reduced by same amount; sticky unchanged.
REQ-012 S1: if after normalization bit[53]=0, exponent SHALL be 0 (subnormal); in_frac=0 with in_sticky=0 yields exact zero, exp 0, sign preserved.
REQ-013 S2 increment: RNE g&(s|lsb); RTZ 0; +inf (g|s)&~sign; -inf (g|s)&sign; lsb = bit[1] of normalized frac.
REQ-014 S2: 53-bit mantissa increment carry-out SHALL give frac 0 and exp+1; subnormal rounding into bit 53 SHALL give exp 1.
REQ-015 out_inexact = g|s of normalized value.
REQ-016 If final exp >= 2047: out_overflow=1, out_inexact=1; RNE or mode rounding toward the sign -> exp 2047 frac 0 (inf); otherwise exp 2046 frac all ones.

Reset
REQ-017 While rst_n=0 at a clock edge: both stage valids, out_valid, all out_* registers SHALL clear to 0; in_ready SHALL be 0 during reset and 1 the cycle after.
REQ-018 Reset mid-operation SHALL discard all in-flight data; nothing emitted afterwards for it.

Configuration
REQ-019 Macro ROUND_NORM_DIRECTED_MODES_EN defined: all four modes per REQ-013/REQ-016.
REQ-020 Macro undefined: in_rm ignored, RNE only; directed-mode logic SHALL not be present.

Verification
REQ-021 in_frac bit53 only, guard 0, sticky 0, exp 1023, RNE -> out exp 1023, frac 0, inexact 0, out_valid 2 cycles after accept.
REQ-022 in_frac bits 54 and 1 set, sticky 0, exp 1000, RNE -> exp 1001, frac 0 (tie to even), inexact 1.
REQ-023 in_frac[53:0] all ones, exp 1023, RNE -> frac 0, exp 1024, inexact 1; same with RTZ -> exp 1023, frac all ones.
REQ-024 exp 2046, bit54 set, RNE -> exp 2047 frac 0, overflow 1; RTZ (macro on) -> exp 2046 frac all ones, overflow 1.
REQ-025 out_ready low 4 cycles, 4 inputs offered back-to-back -> in_ready drops once 2 held; on release all 4 emerge in order, none lost or duplicated.
REQ-026 rst_n low 1 cycle with 2 items in flight -> out_valid 0 next cycle, no stale output; macro off, rm=01 -> identical result to RNE.

Source files
------------

// File: rtl/round_norm.sv
// round_norm: two-stage normalize/round pipeline for a double-precision adder sum.
// Directed rounding modes are present only when ROUND_NORM_DIRECTED_MODES_EN is defined.
module round_norm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [10:0] in_exp,
    input  logic [1:0]  in_rm,
    input  logic [54:0] in_frac,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [10:0] out_exp,
    output logic [51:0] out_frac,
    output logic        out_inexact,
    output logic        out_overflow
);

`ifdef ROUND_NORM_DIRECTED_MODES_EN
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_UP  = 2'b10;
    localparam logic [1:0] RM_DN  = 2'b11;
`endif

    // Leading zeros of a 54-bit value; 54 when the value is zero.
    function automatic logic [5:0] lzc54(input logic [53:0] v);
        logic [5:0] n;
        n = 6'd54;
        for (int unsigned i = 0; i < 54; i++) begin
            if (v[i]) n = 6'(53 - i);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_ready;
    logic s1_adv;
    logic in_fire;

    assign s2_ready = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_ready;
    assign in_ready = rst_n & (~s1_valid | s2_ready);
    assign in_fire  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic [5:0]  lz;
    logic [5:0]  shamt;
    logic [11:0] exp_ext;
    logic [53:0] n_frac;
    logic [11:0] n_exp;
    logic        n_sticky;

    assign exp_ext = {1'b0, in_exp};

    always_comb begin
        n_frac   = in_frac[53:0];
        n_exp    = exp_ext;
        n_sticky = in_sticky;
        lz       = lzc54(in_frac[53:0]);
        shamt    = '0;
        if (in_frac[54]) begin
            n_frac   = in_frac[54:1];
            n_exp    = exp_ext + 12'd1;
            n_sticky = in_sticky | in_frac[0];
        end else if (!in_frac[53] && (in_exp != '0)) begin
            // Shift stops at exponent 1 so the value lands in subnormal form.
            if ({6'd0, lz} < (exp_ext - 12'd1)) begin
                shamt = lz;
            end else begin
                shamt = 6'(exp_ext - 12'd1);
            end
            n_frac = in_frac[53:0] << shamt;
            n_exp  = exp_ext - {6'd0, shamt};
        end
        if (!n_frac[53]) n_exp = '0;
    end

    logic        s1_sign;
    logic [11:0] s1_exp;
    logic [53:0] s1_frac;
    logic        s1_sticky;
`ifdef ROUND_NORM_DIRECTED_MODES_EN
    logic [1:0]  s1_rm;
`else
    logic        unused_rm;
    assign unused_rm = ^in_rm;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_sticky <= 1'b0;
`ifdef ROUND_NORM_DIRECTED_MODES_EN
            s1_rm     <= RM_RNE;
`endif
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_sign   <= in_sign;
                s1_exp    <= n_exp;
                s1_frac   <= n_frac;
                s1_sticky <= n_sticky;
`ifdef ROUND_NORM_DIRECTED_MODES_EN
                s1_rm     <= in_rm;
`endif
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round
    // ------------------------------------------------------------------
    logic        g;
    logic        lsb;
    logic        inc;
    logic        to_inf;
    logic [53:0] sum;
    logic [11:0] r_exp;
    logic [51:0] r_frac;
    logic [10:0] f_exp;
    logic [51:0] f_frac;
    logic        f_inexact;
    logic        f_overflow;

    assign g   = s1_frac[0];
    assign lsb = s1_frac[1];

    always_comb begin
`ifdef ROUND_NORM_DIRECTED_MODES_EN
        case (s1_rm)
            RM_RTZ:  inc = 1'b0;
            RM_UP:   inc = (g | s1_sticky) & ~s1_sign;
            RM_DN:   inc = (g | s1_sticky) & s1_sign;
            default: inc = g & (s1_sticky | lsb);
        endcase
        case (s1_rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_UP:   to_inf = ~s1_sign;
            RM_DN:   to_inf = s1_sign;
            default: to_inf = 1'b1;
        endcase
`else
        inc    = g & (s1_sticky | lsb);
        to_inf = 1'b1;
`endif
    end

    always_comb begin
        sum    = {1'b0, s1_frac[53:1]} + {53'd0, inc};
        r_exp  = s1_exp;
        r_frac = sum[51:0];
        if (sum[53]) begin
            r_exp  = s1_exp + 12'd1;
            r_frac = '0;
        end else if ((s1_exp == '0) && sum[52]) begin
            r_exp = 12'd1;
        end

        f_exp      = r_exp[10:0];
        f_frac     = r_frac;
        f_inexact  = g | s1_sticky;
        f_overflow = 1'b0;
        if (r_exp >= 12'd2047) begin
            f_overflow = 1'b1;
            f_inexact  = 1'b1;
            f_exp      = to_inf ? 11'h7FF : 11'h7FE;
            f_frac     = to_inf ? '0 : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_frac     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_sign     <= s1_sign;
            out_exp      <= f_exp;
            out_frac     <= f_frac;
            out_inexact  <= f_inexact;
            out_overflow <= f_overflow;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
